// File: rtl/gshare_train_scheduler_if.sv
// Handshake bundle between the Gshare predictor, the execute-stage resolver and
// the in-order training scheduler.
interface gshare_train_scheduler_if #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int TAG_W  = 3
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [PC_W-1:0]   alloc_pc;
  logic [HIST_W-1:0] alloc_history;
  logic              alloc_pred_taken;
  logic [TAG_W-1:0]  alloc_tag;

  logic              resolve_valid;
  logic [TAG_W-1:0]  resolve_tag;
  logic              resolve_taken;

  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [HIST_W-1:0] train_history;
  logic [PC_W-1:0]   train_pc;
  logic              flush;

  logic [TAG_W:0]    count;
  logic              empty;

  modport slave (
    input  alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
    input  resolve_valid, resolve_tag, resolve_taken,
    output alloc_ready, alloc_tag,
    output train_valid, train_taken, train_mispredicted, train_history, train_pc,
    output flush, count, empty
  );

  modport master (
    output alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
    output resolve_valid, resolve_tag, resolve_taken,
    input  alloc_ready, alloc_tag,
    input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
    input  flush, count, empty
  );
endinterface

// File: rtl/gshare_train_scheduler.sv
// In-order queue of issued Gshare predictions: out-of-order resolution by tag,
// in-order retirement with one training beat per branch, full flush on mispredict.
module gshare_train_scheduler #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gshare_train_scheduler_if.slave bus
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q;
  logic [DEPTH-1:0]  valid_q, resolved_q;

  logic [DEPTH-1:0]  actual_q, pred_q;
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [HIST_W-1:0] hist_q [DEPTH];

  logic              train_valid_q, train_taken_q, train_mis_q, flush_q;
  logic [PC_W-1:0]   train_pc_q;
  logic [HIST_W-1:0] train_hist_q;

  logic not_full, alloc_fire, resolve_hit, retire, mispredict;

  always_comb begin
    not_full    = (count_q != FULL_CNT);
    retire      = valid_q[head_q] & resolved_q[head_q];
    mispredict  = retire & (actual_q[head_q] ^ pred_q[head_q]);
    // Anything arriving on a mispredict edge belongs to the wrong path.
    alloc_fire  = bus.alloc_valid & not_full & ~mispredict;
    resolve_hit = bus.resolve_valid & valid_q[bus.resolve_tag] &
                  ~resolved_q[bus.resolve_tag] & ~mispredict;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (mispredict) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (retire)     head_q <= head_q + PTR_ONE;
      if (alloc_fire) tail_q <= tail_q + PTR_ONE;
      count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
    end
  end

  // Retire and alloc never hit the same slot: that would require a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mispredict) begin
          valid_q[i]    <= 1'b0;
          resolved_q[i] <= 1'b0;
        end else if (retire && head_q == TAG_W'(i)) begin
          valid_q[i]    <= 1'b0;
          resolved_q[i] <= 1'b0;
        end else if (alloc_fire && tail_q == TAG_W'(i)) begin
          valid_q[i]    <= 1'b1;
          resolved_q[i] <= 1'b0;
        end else if (resolve_hit && bus.resolve_tag == TAG_W'(i)) begin
          resolved_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]   <= bus.alloc_pc;
      hist_q[tail_q] <= bus.alloc_history;
      pred_q[tail_q] <= bus.alloc_pred_taken;
    end
    if (resolve_hit) actual_q[bus.resolve_tag] <= bus.resolve_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_valid_q <= 1'b0;
      train_taken_q <= 1'b0;
      train_mis_q   <= 1'b0;
      train_pc_q    <= '0;
      train_hist_q  <= '0;
      flush_q       <= 1'b0;
    end else begin
      train_valid_q <= retire;
      flush_q       <= mispredict;
      if (retire) begin
        train_taken_q <= actual_q[head_q];
        train_mis_q   <= mispredict;
        train_pc_q    <= pc_q[head_q];
        train_hist_q  <= hist_q[head_q];
      end
    end
  end

  assign bus.alloc_ready        = not_full;
  assign bus.alloc_tag          = tail_q;
  assign bus.count              = count_q;
  assign bus.empty              = (count_q == '0);
  assign bus.train_valid        = train_valid_q;
  assign bus.train_taken        = train_taken_q;
  assign bus.train_mispredicted = train_mis_q;
  assign bus.train_pc           = train_pc_q;
  assign bus.train_history      = train_hist_q;
  assign bus.flush              = flush_q;

endmodule
